// File: rtl/pipelined_cla_adder.sv
// ============================================================================
// Module   : pipelined_cla_adder
// Brief    : Valid/ready pipelined carry-lookahead adder/subtractor, GPS
//            4-bit lookahead groups resolved per stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GPS   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf
);

    localparam int c_gb  = 4 * GPS;
    localparam int c_lat = WIDTH / c_gb;

    // Returns {c4,c3,c2,c1,c0}; every carry is a flat sum of products.
    function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                        input logic c0);
        logic [4:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    // Resolves the GPS groups owned by stage k; returns {carry into group MSB, carry out, sum}.
    function automatic logic [WIDTH+1:0] stage_fn(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] s_in,
                                                  input logic             ci,
                                                  input int               k);
        logic [WIDTH-1:0] s;
        logic             c;
        logic             cm;
        logic [3:0]       g;
        logic [3:0]       p;
        logic [4:0]       cv;
        int               base;
        s  = s_in;
        c  = ci;
        cm = 1'b0;
        for (int j = 0; j < GPS; j++) begin
            base          = k * c_gb + 4 * j;
            g             = a[base +: 4] & b[base +: 4];
            p             = a[base +: 4] ^ b[base +: 4];
            cv            = cla4(g, p, c);
            s[base +: 4]  = p ^ cv[3:0];
            c             = cv[4];
            cm            = cv[3];
        end
        return {cm, c, s};
    endfunction

    logic [WIDTH-1:0] r_a  [c_lat];
    logic [WIDTH-1:0] r_b  [c_lat];
    logic [WIDTH-1:0] r_s  [c_lat];
    logic             r_c  [c_lat];
    logic             r_cm [c_lat];
    logic [c_lat-1:0] r_v;

    logic [WIDTH-1:0] w_a_in   [c_lat];
    logic [WIDTH-1:0] w_b_in   [c_lat];
    logic [WIDTH-1:0] w_s_in   [c_lat];
    logic             w_c_in   [c_lat];
    logic [WIDTH-1:0] w_s_nxt  [c_lat];
    logic             w_c_nxt  [c_lat];
    logic             w_cm_nxt [c_lat];
    logic [c_lat-1:0] w_load;
    logic [c_lat-1:0] w_vin;
    logic             w_ld;

    generate
        for (genvar k = 0; k < c_lat; k++) begin : g_stage
            if (k == 0) begin : g_src_in
                assign w_a_in[k] = A;
                assign w_b_in[k] = sub ? ~B : B;
                assign w_s_in[k] = '0;
                assign w_c_in[k] = sub | Cin;
            end else begin : g_src_prev
                assign w_a_in[k] = r_a[k-1];
                assign w_b_in[k] = r_b[k-1];
                assign w_s_in[k] = r_s[k-1];
                assign w_c_in[k] = r_c[k-1];
            end
            assign {w_cm_nxt[k], w_c_nxt[k], w_s_nxt[k]} =
                stage_fn(w_a_in[k], w_b_in[k], w_s_in[k], w_c_in[k], k);
        end
    endgenerate

    // Load enables propagate backwards from the output; a stage loads when empty
    // or when its successor is taking its current contents.
    always_comb begin
        w_load          = '0;
        w_ld            = ~r_v[c_lat-1] | out_ready;
        w_load[c_lat-1] = w_ld;
        for (int k = c_lat - 2; k >= 0; k--) begin
            w_ld      = ~r_v[k] | w_ld;
            w_load[k] = w_ld;
        end
    end

    always_comb begin
        w_vin    = '0;
        w_vin[0] = in_valid;
        for (int k = 1; k < c_lat; k++) begin
            w_vin[k] = r_v[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            for (int k = 0; k < c_lat; k++) begin
                r_a[k]  <= '0;
                r_b[k]  <= '0;
                r_s[k]  <= '0;
                r_c[k]  <= 1'b0;
                r_cm[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < c_lat; k++) begin
                if (w_load[k]) begin
                    r_v[k]  <= w_vin[k];
                    r_a[k]  <= w_a_in[k];
                    r_b[k]  <= w_b_in[k];
                    r_s[k]  <= w_s_nxt[k];
                    r_c[k]  <= w_c_nxt[k];
                    r_cm[k] <= w_cm_nxt[k];
                end
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_v[c_lat-1];
    assign S         = out_valid ? r_s[c_lat-1] : '0;
    assign Cout      = out_valid & r_c[c_lat-1];
    assign ovf       = out_valid & (r_c[c_lat-1] ^ r_cm[c_lat-1]);

endmodule

`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
// ============================================================================
// Module   : tb_pipelined_cla_adder
// Brief    : Self-checking bench for pipelined_cla_adder (WIDTH=16, GPS=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pipelined_cla_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] S;
    logic        Cout;
    logic        ovf;

    int          checks = 0;
    int          errors = 0;
    logic [17:0] q[$];

    pipelined_cla_adder #(.WIDTH(16), .GPS(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {Cout, ovf, S}; overflow from operand/result sign bits.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic s);
        logic [15:0] be;
        logic [16:0] sum;
        logic        o;
        be  = s ? ~b : b;
        sum = {1'b0, a} + {1'b0, be} + {16'd0, (s | c)};
        o   = (a[15] == be[15]) && (sum[15] != a[15]);
        return {sum[16], o, sum[15:0]};
    endfunction

    // Scoreboard: transfers are decided by the values held across the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!out_valid) check("idle_zero", {14'd0, Cout, ovf, S}, 32'd0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("unexpected_out", {31'd0, out_valid}, 32'd0);
                else               check("result", {14'd0, Cout, ovf, S}, {14'd0, q.pop_front()});
            end
            if (in_valid && in_ready) q.push_back(model(A, B, Cin, sub));
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
        int n;
        A = a; B = b; Cin = c; sub = s; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Accept edge is the first of the LAT edges; out_valid shows after the LAT-th.
    task automatic latency_check(input logic [15:0] exp_s, input logic exp_c);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lat_early", {31'd0, out_valid}, 32'd0);
        end
        @(negedge clk);
        check("lat_on", {31'd0, out_valid}, 32'd1);
        check("lat_s", {16'd0, S}, {16'd0, exp_s});
        check("lat_cout", {31'd0, Cout}, {31'd0, exp_c});
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #3;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {14'd0, Cout, ovf, S}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Carry out of the MSB
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        latency_check(16'h0000, 1'b1);
        repeat (4) @(posedge clk); #1;

        // Signed overflow and subtract cases, back to back
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b1, 1'b0);
        send(16'h8000, 16'h0001, 1'b1, 1'b1);
        send(16'h0003, 16'h0005, 1'b0, 1'b1);
        repeat (8) @(posedge clk); #1;

        // Streaming: one accept per cycle, eight consecutive outputs
        for (int t = 0; t < 13; t++) begin
            if (t < 8) begin
                A = 16'(t + 1); B = 16'(t + 1) << 8; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (t < 8) check("stream_ready", {31'd0, in_ready}, 32'd1);
            check("stream_valid", {31'd0, out_valid}, {31'd0, (t >= 4 && t <= 11)});
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk); #1;

        // Backpressure: fill, hold, release
        begin
            int k;
            k = 0;
            out_ready = 1'b0;
            for (int t = 0; t < 6; t++) begin
                A = 16'h1000 + 16'(k); B = 16'(k); Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
                @(negedge clk);
                check("bp_ready", {31'd0, in_ready}, {31'd0, (t < 4)});
                if (in_ready) k++;
                if (t >= 4) begin
                    check("bp_hold_v", {31'd0, out_valid}, 32'd1);
                    check("bp_hold_s", {16'd0, S}, 32'h1000);
                end
                @(posedge clk); #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            repeat (8) @(posedge clk); #1;
            check("bp_accepts", k, 4);
            check("bp_drain", q.size(), 0);
        end

        // Reset with three results in flight
        out_ready = 1'b0;
        send(16'h0011, 16'h0001, 1'b0, 1'b0);
        send(16'h0022, 16'h0002, 1'b0, 1'b0);
        send(16'h0033, 16'h0003, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_s", {16'd0, S}, 32'd0);
        check("async_rst_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            check("no_stale", {31'd0, out_valid}, 32'd0);
            @(posedge clk); #1;
        end
        send(16'h0002, 16'h0003, 1'b0, 1'b0);
        latency_check(16'h0005, 1'b0);
        repeat (4) @(posedge clk); #1;
        check("final_drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
